// File: rtl/merlin_pkg.sv
//------------------------------------------------------------------------------
// Module   : merlin_pkg
// Brief    : Shared types and constants for the Merlin execute stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package merlin_pkg;

  typedef enum logic [1:0] {
    ZONE_NONE    = 2'd0,
    ZONE_REGFILE = 2'd1,
    ZONE_LOADQ   = 2'd2,
    ZONE_STOREQ  = 2'd3
  } t_zone;

  localparam logic [3:0] C_ALU_ADD    = 4'd0;
  localparam logic [3:0] C_ALU_SUB    = 4'd1;
  localparam logic [3:0] C_ALU_SLL    = 4'd2;
  localparam logic [3:0] C_ALU_SLT    = 4'd3;
  localparam logic [3:0] C_ALU_SLTU   = 4'd4;
  localparam logic [3:0] C_ALU_XOR    = 4'd5;
  localparam logic [3:0] C_ALU_SRL    = 4'd6;
  localparam logic [3:0] C_ALU_SRA    = 4'd7;
  localparam logic [3:0] C_ALU_OR     = 4'd8;
  localparam logic [3:0] C_ALU_AND    = 4'd9;
  localparam logic [3:0] C_ALU_PASS_R = 4'd10;

  localparam logic [2:0] C_F3_BEQ  = 3'b000;
  localparam logic [2:0] C_F3_BNE  = 3'b001;
  localparam logic [2:0] C_F3_BLT  = 3'b100;
  localparam logic [2:0] C_F3_BGE  = 3'b101;
  localparam logic [2:0] C_F3_BLTU = 3'b110;
  localparam logic [2:0] C_F3_BGEU = 3'b111;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_hs_if.sv
//------------------------------------------------------------------------------
// Module   : ex_stage_hs_if
// Brief    : Decoder-to-execute dav/ack instruction bus. The ilen field only
//            exists when MERLIN_RVC_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ex_stage_hs_if
  import merlin_pkg::*;
#(
  parameter int C_XLEN     = 32,
  parameter int C_ALU_OP_W = 4
);
  logic                  dav;
  logic                  ack;
  t_zone                 zone;
  logic [C_ALU_OP_W-1:0] alu_op;
  logic                  branch;
  logic                  jump;
  logic                  link;
`ifdef MERLIN_RVC_EN
  logic                  ilen;
`endif
  logic [C_XLEN-1:0]     pc;
  logic [C_XLEN-1:0]     operand_left;
  logic [C_XLEN-1:0]     operand_right;
  logic [C_XLEN-1:0]     regs1_data;
  logic [C_XLEN-1:0]     regs2_data;
  logic [4:0]            regd_addr;
  logic [2:0]            funct3;
  logic                  csr_access;

  modport master (
    input  ack,
    output dav, zone, alu_op, branch, jump, link, pc, operand_left,
           operand_right, regs1_data, regs2_data, regd_addr, funct3, csr_access
`ifdef MERLIN_RVC_EN
    , ilen
`endif
  );

  modport slave (
    output ack,
    input  dav, zone, alu_op, branch, jump, link, pc, operand_left,
           operand_right, regs1_data, regs2_data, regd_addr, funct3, csr_access
`ifdef MERLIN_RVC_EN
    , ilen
`endif
  );

endinterface

`default_nettype wire

// File: rtl/ex_stage_hs_alu_cmp.sv
//------------------------------------------------------------------------------
// Module   : alu_cmp
// Brief    : Combinational ALU and branch comparator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_cmp
  import merlin_pkg::*;
#(
  parameter int C_XLEN     = 32,
  parameter int C_ALU_OP_W = 4
) (
  input  logic [C_ALU_OP_W-1:0] i_alu_op,
  input  logic [C_XLEN-1:0]     i_left,
  input  logic [C_XLEN-1:0]     i_right,
  input  logic [2:0]            i_funct3,
  input  logic [C_XLEN-1:0]     i_cmp_left,
  input  logic [C_XLEN-1:0]     i_cmp_right,
  output logic [C_XLEN-1:0]     o_result,
  output logic                  o_cmp_true
);

  localparam int C_SH_W = $clog2(C_XLEN);

  logic [3:0]        w_op;
  logic [C_SH_W-1:0] w_shamt;
  logic              w_eq;
  logic              w_lt;
  logic              w_ltu;

  assign w_op    = i_alu_op[3:0];
  assign w_shamt = i_right[C_SH_W-1:0];
  assign w_eq    = (i_cmp_left == i_cmp_right);
  assign w_lt    = ($signed(i_cmp_left) < $signed(i_cmp_right));
  assign w_ltu   = (i_cmp_left < i_cmp_right);

  always_comb begin
    o_result = '0;
    case (w_op)
      C_ALU_ADD:    o_result = i_left + i_right;
      C_ALU_SUB:    o_result = i_left - i_right;
      C_ALU_SLL:    o_result = i_left << w_shamt;
      C_ALU_SLT:    o_result = {{(C_XLEN-1){1'b0}}, $signed(i_left) < $signed(i_right)};
      C_ALU_SLTU:   o_result = {{(C_XLEN-1){1'b0}}, i_left < i_right};
      C_ALU_XOR:    o_result = i_left ^ i_right;
      C_ALU_SRL:    o_result = i_left >> w_shamt;
      C_ALU_SRA:    o_result = $unsigned($signed(i_left) >>> w_shamt);
      C_ALU_OR:     o_result = i_left | i_right;
      C_ALU_AND:    o_result = i_left & i_right;
      C_ALU_PASS_R: o_result = i_right;
      default:      o_result = '0;
    endcase
  end

  // Reserved funct3 encodings (010, 011) never take.
  always_comb begin
    o_cmp_true = 1'b0;
    case (i_funct3)
      C_F3_BEQ:  o_cmp_true = w_eq;
      C_F3_BNE:  o_cmp_true = !w_eq;
      C_F3_BLT:  o_cmp_true = w_lt;
      C_F3_BGE:  o_cmp_true = !w_lt;
      C_F3_BLTU: o_cmp_true = w_ltu;
      C_F3_BGEU: o_cmp_true = !w_ltu;
      default:   o_cmp_true = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage_hs.sv
//------------------------------------------------------------------------------
// Module   : ex_stage_hs
// Brief    : Merlin execute stage with dav/ack handshake, LSQ stall, branch
//            resolution and wrong-path squash. Optional: MERLIN_RVC_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_stage_hs
  import merlin_pkg::*;
#(
  parameter int C_XLEN     = 32,
  parameter int C_ALU_OP_W = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  ex_stage_hs_if.slave      ids,
  input  logic [C_XLEN-1:0] csr_rd_data_i,
  output logic              wb_regd_wr_o,
  output logic [4:0]        wb_regd_addr_o,
  output logic [C_XLEN-1:0] wb_regd_data_o,
  output logic              hvec_vec_strobe_o,
  output logic [C_XLEN-1:0] hvec_vec_o,
  output logic              hvec_misalign_o,
  output logic [C_XLEN-1:0] hvec_pc_o,
  input  logic              lsq_lq_full_i,
  input  logic              lsq_sq_full_i,
  output logic              lsq_lq_wr_o,
  output logic              lsq_sq_wr_o,
  output logic [2:0]        lsq_funct3_o,
  output logic [4:0]        lsq_regd_addr_o,
  output logic [C_XLEN-1:0] lsq_regs2_data_o,
  output logic [C_XLEN-1:0] lsq_addr_o
);

  generate
    if (!xlen_legal(C_XLEN)) begin : g_bad_xlen
      $error("ex_stage_hs: C_XLEN must be 32 or 64");
    end
  endgenerate

  logic              r_wb_wr;
  logic [4:0]        r_wb_addr;
  logic [C_XLEN-1:0] r_wb_data;
  logic              r_vec_strobe;
  logic [C_XLEN-1:0] r_vec;
  logic              r_misalign;
  logic [C_XLEN-1:0] r_hvec_pc;
  logic              r_lq_wr;
  logic              r_sq_wr;
  logic [2:0]        r_lsq_funct3;
  logic [4:0]        r_lsq_regd_addr;
  logic [C_XLEN-1:0] r_lsq_regs2_data;
  logic [C_XLEN-1:0] r_lsq_addr;

  logic              w_stall;
  logic              w_ack;
  logic              w_live;
  logic              w_commit;
  logic              w_taken;
  logic              w_misalign;
  logic              w_cmp_true;
  logic [C_XLEN-1:0] w_alu;
  logic [C_XLEN-1:0] w_target;
  logic [C_XLEN-1:0] w_inc;
  logic [C_XLEN-1:0] w_wb_data;

  alu_cmp #(
    .C_XLEN     (C_XLEN),
    .C_ALU_OP_W (C_ALU_OP_W)
  ) u_alu_cmp (
    .i_alu_op    (ids.alu_op),
    .i_left      (ids.operand_left),
    .i_right     (ids.operand_right),
    .i_funct3    (ids.funct3),
    .i_cmp_left  (ids.regs1_data),
    .i_cmp_right (ids.regs2_data),
    .o_result    (w_alu),
    .o_cmp_true  (w_cmp_true)
  );

  assign w_stall  = (r_lq_wr && lsq_lq_full_i) || (r_sq_wr && lsq_sq_full_i);
  assign w_ack    = clk_en_i && !w_stall;
  assign ids.ack  = w_ack;

  // Anything accepted while a redirect/fault is visible is wrong-path work.
  assign w_live   = ids.dav && w_ack && !(r_vec_strobe || r_misalign);
  assign w_taken  = ids.jump || (ids.branch && w_cmp_true);
  assign w_target = {w_alu[C_XLEN-1:1], 1'b0};

`ifdef MERLIN_RVC_EN
  assign w_inc      = ids.ilen ? C_XLEN'(4) : C_XLEN'(2);
  assign w_misalign = 1'b0;
`else
  assign w_inc      = C_XLEN'(4);
  assign w_misalign = w_taken && w_target[1];
`endif

  // A faulting jump retires nothing: no link write and no LSQ entry.
  assign w_commit  = w_live && !w_misalign;
  assign w_wb_data = ids.csr_access ? csr_rd_data_i
                   : ids.link       ? (ids.pc + w_inc)
                   :                  w_alu;

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_wb_wr      <= 1'b0;
      r_lq_wr      <= 1'b0;
      r_sq_wr      <= 1'b0;
      r_vec_strobe <= 1'b0;
      r_misalign   <= 1'b0;
    end else if (w_ack) begin
      r_wb_wr      <= w_commit && (ids.zone == ZONE_REGFILE) && (ids.regd_addr != 5'd0);
      r_lq_wr      <= w_commit && (ids.zone == ZONE_LOADQ);
      r_sq_wr      <= w_commit && (ids.zone == ZONE_STOREQ);
      r_vec_strobe <= w_live && w_taken && !w_misalign;
      r_misalign   <= w_live && w_misalign;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_wb_addr        <= '0;
      r_wb_data        <= '0;
      r_vec            <= '0;
      r_hvec_pc        <= '0;
      r_lsq_funct3     <= '0;
      r_lsq_regd_addr  <= '0;
      r_lsq_regs2_data <= '0;
      r_lsq_addr       <= '0;
    end else if (w_live) begin
      r_wb_addr        <= ids.regd_addr;
      r_wb_data        <= w_wb_data;
      r_vec            <= w_target;
      r_hvec_pc        <= ids.pc;
      r_lsq_funct3     <= ids.funct3;
      r_lsq_regd_addr  <= ids.regd_addr;
      r_lsq_regs2_data <= ids.regs2_data;
      r_lsq_addr       <= w_alu;
    end
  end

  assign wb_regd_wr_o      = r_wb_wr;
  assign wb_regd_addr_o    = r_wb_addr;
  assign wb_regd_data_o    = r_wb_data;
  assign hvec_vec_strobe_o = r_vec_strobe;
  assign hvec_vec_o        = r_vec;
  assign hvec_misalign_o   = r_misalign;
  assign hvec_pc_o         = r_hvec_pc;
  assign lsq_lq_wr_o       = r_lq_wr;
  assign lsq_sq_wr_o       = r_sq_wr;
  assign lsq_funct3_o      = r_lsq_funct3;
  assign lsq_regd_addr_o   = r_lsq_regd_addr;
  assign lsq_regs2_data_o  = r_lsq_regs2_data;
  assign lsq_addr_o        = r_lsq_addr;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_hs.sv
//------------------------------------------------------------------------------
// Module   : tb_ex_stage_hs
// Brief    : Scoreboard bench for ex_stage_hs (C_XLEN=32); follows MERLIN_RVC_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_stage_hs;
  import merlin_pkg::*;

  localparam int XL = 32;

  typedef struct {
    bit          dav;
    t_zone       zone;
    logic [3:0]  op;
    bit          br, jmp, lnk, ilen, csr;
    logic [31:0] pc, l, r, s1, s2, csrd;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } stim_t;

  typedef struct {
    bit          squashed;
    bit          wb, lq, sq, strobe, mis;
    logic [4:0]  rd;
    logic [31:0] wdata, addr, sdata, vec, hpc;
    logic [2:0]  f3;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        clk_en = 1'b1;
  logic        lq_full = 1'b0, sq_full = 1'b0;
  logic [31:0] csr_rd_data = '0;
  logic        wb_wr, strobe, mis, lq_wr, sq_wr;
  logic [4:0]  wb_addr, lsq_rd;
  logic [2:0]  lsq_f3;
  logic [31:0] wb_data, vec, hpc, lsq_sdata, lsq_addr;

  ex_stage_hs_if #(.C_XLEN(XL), .C_ALU_OP_W(4)) ifc ();

  ex_stage_hs #(.C_XLEN(XL), .C_ALU_OP_W(4)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en), .ids(ifc),
    .csr_rd_data_i(csr_rd_data),
    .wb_regd_wr_o(wb_wr), .wb_regd_addr_o(wb_addr), .wb_regd_data_o(wb_data),
    .hvec_vec_strobe_o(strobe), .hvec_vec_o(vec), .hvec_misalign_o(mis), .hvec_pc_o(hpc),
    .lsq_lq_full_i(lq_full), .lsq_sq_full_i(sq_full),
    .lsq_lq_wr_o(lq_wr), .lsq_sq_wr_o(sq_wr), .lsq_funct3_o(lsq_f3),
    .lsq_regd_addr_o(lsq_rd), .lsq_regs2_data_o(lsq_sdata), .lsq_addr_o(lsq_addr)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_err = 0;
  exp_t  sb_q[$];
  stim_t cur;
  bit    m_lq_pend = 0, m_sq_pend = 0, m_redir = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (ISA-level semantics) ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << b[4:0];
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> b[4:0];
      4'd7:  return $unsigned($signed(a) >>> b[4:0]);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) <  $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a <  b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t ref_exec(input stim_t s);
    exp_t        e;
    logic [31:0] res, tgt, inc;
    bit          taken;
    res   = ref_alu(s.op, s.l, s.r);
    tgt   = res & 32'hFFFF_FFFE;
    taken = s.jmp || (s.br && ref_cond(s.f3, s.s1, s.s2));
`ifdef MERLIN_RVC_EN
    inc   = s.ilen ? 32'd4 : 32'd2;
    e.mis = 1'b0;
`else
    inc   = 32'd4;
    e.mis = taken && tgt[1];
`endif
    e.squashed = 1'b0;
    e.strobe   = taken && !e.mis;
    e.vec      = tgt;
    e.hpc      = s.pc;
    e.wb       = !e.mis && s.zone == ZONE_REGFILE && s.rd != 5'd0;
    e.rd       = s.rd;
    e.wdata    = s.csr ? s.csrd : (s.lnk ? s.pc + inc : res);
    e.lq       = !e.mis && s.zone == ZONE_LOADQ;
    e.sq       = !e.mis && s.zone == ZONE_STOREQ;
    e.f3       = s.f3;
    e.addr     = res;
    e.sdata    = s.s2;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    cur = s;
    ifc.dav = s.dav; ifc.zone = s.zone; ifc.alu_op = s.op;
    ifc.branch = s.br; ifc.jump = s.jmp; ifc.link = s.lnk;
`ifdef MERLIN_RVC_EN
    ifc.ilen = s.ilen;
`endif
    ifc.pc = s.pc; ifc.operand_left = s.l; ifc.operand_right = s.r;
    ifc.regs1_data = s.s1; ifc.regs2_data = s.s2; ifc.regd_addr = s.rd;
    ifc.funct3 = s.f3; ifc.csr_access = s.csr; csr_rd_data = s.csrd;
  endtask

  function automatic stim_t mk(input t_zone z, input logic [3:0] op, input logic [31:0] l,
                               input logic [31:0] r, input logic [4:0] rd);
    stim_t s;
    s.dav = 1; s.zone = z; s.op = op; s.br = 0; s.jmp = 0; s.lnk = 0; s.ilen = 1;
    s.csr = 0; s.pc = 32'h0000_0100; s.l = l; s.r = r; s.s1 = 0; s.s2 = 0;
    s.csrd = 32'hC5C5_0000; s.rd = rd; s.f3 = 3'b010;
    return s;
  endfunction

  // One clock: predict ack at the negedge, push the expected result of an
  // accepted instruction, then advance the model at the clock edge.
  task automatic step();
    bit   stall, exp_ack, acc, n_lq, n_sq, n_redir;
    exp_t e;
    @(negedge clk);
    stall   = (m_lq_pend && lq_full) || (m_sq_pend && sq_full);
    exp_ack = clk_en && !stall;
    chk("ids_ack", ifc.ack, exp_ack);
    acc = cur.dav && exp_ack;
    n_lq = m_lq_pend; n_sq = m_sq_pend; n_redir = m_redir;
    if (clk_en && !stall) begin
      n_lq = 0; n_sq = 0; n_redir = 0;
      if (acc && !m_redir) begin
        e = ref_exec(cur);
        sb_q.push_back(e);
        n_lq = e.lq; n_sq = e.sq; n_redir = e.strobe || e.mis;
      end else if (acc) begin
        e = '{squashed: 1'b1, default: '0};
        sb_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    m_lq_pend = n_lq; m_sq_pend = n_sq; m_redir = n_redir;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_wr"}, wb_wr, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_lq_wr"}, lq_wr, 0);
    chk({tag, "_sq_wr"}, sq_wr, 0);
    chk({tag, "_strobe"}, strobe, 0);
    chk({tag, "_misalign"}, mis, 0);
    chk({tag, "_lsq_addr"}, lsq_addr, 0);
    chk({tag, "_hvec_pc"}, hpc, 0);
  endtask

  // ---------------- monitor ----------------
  bit mon_pend = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!resetb) begin
      mon_pend = 0;
    end else begin
      if (mon_pend) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("wb_wr", wb_wr, e.wb);
          chk("lq_wr", lq_wr, e.lq);
          chk("sq_wr", sq_wr, e.sq);
          chk("vec_strobe", strobe, e.strobe);
          chk("misalign", mis, e.mis);
          if (!e.squashed) begin
            if (e.wb) begin
              chk("wb_addr", wb_addr, e.rd);
              chk("wb_data", wb_data, e.wdata);
            end
            if (e.lq || e.sq) begin
              chk("lsq_funct3", lsq_f3, e.f3);
              chk("lsq_addr", lsq_addr, e.addr);
            end
            if (e.lq) chk("lsq_regd_addr", lsq_rd, e.rd);
            if (e.sq) chk("lsq_regs2_data", lsq_sdata, e.sdata);
            if (e.strobe) chk("hvec_vec", vec, e.vec);
            if (e.strobe || e.mis) chk("hvec_pc", hpc, e.hpc);
          end
        end
      end
      mon_pend = ifc.dav && ifc.ack;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    s = mk(ZONE_NONE, 4'd0, 0, 0, 0);
    s.dav = 0;
    drive(s);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    resetb = 1'b1;
    @(posedge clk); #1;

    // ADD 5+7 -> x3
    drive(mk(ZONE_REGFILE, C_ALU_ADD, 32'd5, 32'd7, 5'd3));
    step();
    chk("add_data_direct", wb_data, 32'd12);
    chk("add_no_lsq", lq_wr | sq_wr, 0);

    // Load to 0x100 held off by a full load queue for three cycles
    s = mk(ZONE_LOADQ, C_ALU_ADD, 32'h0F0, 32'h010, 5'd7);
    drive(s);
    step();
    drive(mk(ZONE_REGFILE, C_ALU_XOR, 32'hFF00, 32'h0FF0, 5'd9));
    lq_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_lq_wr_hold", lq_wr, 1);
      chk("stall_lsq_addr_hold", lsq_addr, 32'h100);
    end
    lq_full = 1'b0;
    step();
    chk("lq_wr_drop_after_xfer", lq_wr, 0);

    // BEQ taken, then an ADD that must be squashed
    s = mk(ZONE_NONE, C_ALU_ADD, 32'h1000, 32'h1000, 5'd0);
    s.br = 1; s.f3 = 3'b000; s.s1 = 32'd9; s.s2 = 32'd9; s.pc = 32'h1000;
    drive(s);
    step();
    chk("beq_strobe_direct", strobe, 1);
    chk("beq_vec_direct", vec, 32'h2000);
    drive(mk(ZONE_REGFILE, C_ALU_ADD, 32'd1, 32'd1, 5'd4));
    step();
    chk("beq_strobe_one_cycle", strobe, 0);
    chk("squash_no_wb", wb_wr, 0);

    // JAL at the top of the address space: link wraps to 0
    s = mk(ZONE_REGFILE, C_ALU_ADD, 32'h400, 32'h0, 5'd1);
    s.jmp = 1; s.lnk = 1; s.pc = 32'hFFFF_FFFC;
    drive(s);
    step();
    chk("jal_wrap_data", wb_data, 32'h0);
    s.dav = 0;
    drive(s);
    step();

    // JALR to 0x1002 with a compressed-length instruction
    s = mk(ZONE_REGFILE, C_ALU_ADD, 32'h1000, 32'h2, 5'd5);
    s.jmp = 1; s.lnk = 1; s.ilen = 0; s.pc = 32'h0000_0800;
    drive(s);
    step();
    drive(mk(ZONE_REGFILE, C_ALU_ADD, 32'd3, 32'd3, 5'd6));
    step();
    s.dav = 0;
    drive(s);
    step();

    // Reset in the middle of a store-queue stall
    drive(mk(ZONE_STOREQ, C_ALU_ADD, 32'h200, 32'h4, 5'd0));
    step();
    sq_full = 1'b1;
    s = mk(ZONE_REGFILE, C_ALU_OR, 32'h1, 32'h2, 5'd8);
    s.dav = 0;
    drive(s);
    step();
    resetb = 1'b0;
    #1;
    chk_all_zero("midstall_reset");
    sb_q.delete();
    m_lq_pend = 0; m_sq_pend = 0; m_redir = 0;
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk); #1;
    s.dav = 1;
    drive(s);
    step();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned kind;
      s = mk(t_zone'($urandom_range(0, 3)), 4'($urandom_range(0, 11)), $urandom, $urandom,
             5'($urandom_range(0, 31)));
      s.dav  = ($urandom_range(0, 9) < 8);
      s.pc   = $urandom & 32'hFFFF_FFFE;
      s.s1   = ($urandom_range(0, 1) == 1) ? 32'd77 : $urandom;
      s.s2   = ($urandom_range(0, 1) == 1) ? 32'd77 : $urandom;
      s.f3   = 3'($urandom_range(0, 7));
      s.csr  = ($urandom_range(0, 9) == 0);
      s.csrd = $urandom;
      s.ilen = ($urandom_range(0, 1) == 1);
      kind   = $urandom_range(0, 9);
      if (kind < 2) begin
        s.br = 1; s.zone = ZONE_NONE;
      end else if (kind == 2) begin
        s.jmp = 1; s.lnk = 1; s.zone = ZONE_REGFILE;
      end
      drive(s);
      clk_en  = ($urandom_range(0, 9) != 0);
      lq_full = ($urandom_range(0, 9) < 3);
      sq_full = ($urandom_range(0, 9) < 3);
      step();
    end

    s.dav = 0;
    drive(s);
    clk_en = 1'b1; lq_full = 1'b0; sq_full = 1'b0;
    step();
    step();
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_stage_hs.md
Name: ex_stage_hs

Overview:
Next-generation execute stage for the Merlin core, parametrised in XLEN (32/64). Sits between the instruction decoder (ids) and write-back, hart vectoring (hvec) and load/store queue (lsq). Adds what the first execute stage lacks: a real dav/ack handshake, LSQ back-pressure stalls, branch/jump resolution with redirect, and one-cycle wrong-path squash.

Parameters:
C_XLEN, 32, datapath width; legal values 32 and 64.
C_ALU_OP_W, 4, width of the ALU opcode field.

Ports:
clk_i  in  1  clock
resetb_i  in  1  reset
clk_en_i  in  1  global clock enable; 0 freezes all state, forces ids_ack_o=0
ids_dav_i  in  1  decoder holds a valid instruction
ids_ack_o  out  1  instruction accepted this cycle
ids_zone_i  in  t_zone  destination: ZONE_NONE/REGFILE/LOADQ/STOREQ
ids_alu_op_i  in  C_ALU_OP_W  ALU operation
ids_branch_i  in  1  conditional branch (compare selected by ids_funct3_i)
ids_jump_i  in  1  unconditional jump (JAL/JALR)
ids_link_i  in  1  write pc+inc to regd
ids_ilen_i  in  1  1 = 32-bit instruction, 0 = 16-bit (MERLIN_RVC_EN only)
ids_pc_i  in  C_XLEN  instruction PC
ids_operand_left_i  in  C_XLEN  ALU left operand
ids_operand_right_i  in  C_XLEN  ALU right operand
ids_regs1_data_i  in  C_XLEN  compare left operand
ids_regs2_data_i  in  C_XLEN  compare right operand / store data
ids_regd_addr_i  in  5  destination register
ids_funct3_i  in  3  compare select / LSQ size+sign
ids_csr_access_i  in  1  CSR instruction
csr_rd_data_i  in  C_XLEN  CSR read data, valid in the acceptance cycle
wb_regd_wr_o  out  1  regfile write strobe
wb_regd_addr_o  out  5  write address
wb_regd_data_o  out  C_XLEN  write data
hvec_vec_strobe_o  out  1  redirect pulse
hvec_vec_o  out  C_XLEN  redirect target
hvec_misalign_o  out  1  misaligned-target exception pulse
hvec_pc_o  out  C_XLEN  PC of the redirecting/faulting instruction
lsq_lq_full_i  in  1  load queue full
lsq_sq_full_i  in  1  store queue full
lsq_lq_wr_o  out  1  load entry valid
lsq_sq_wr_o  out  1  store entry valid
lsq_funct3_o  out  3  access size/sign
lsq_regd_addr_o  out  5  load destination
lsq_regs2_data_o  out  C_XLEN  store data
lsq_addr_o  out  C_XLEN  effective address

Behaviour:
- Clocking: clk_i; reset resetb_i asynchronous, active-low. All registered outputs reset to 0.
- Acceptance: accepted when ids_dav_i && ids_ack_o. ids_ack_o = clk_en_i && !stall. Latency is one cycle: results on the registered outputs in cycle N+1.
- Stall: stall = (lsq_lq_wr_o && lsq_lq_full_i) || (lsq_sq_wr_o && lsq_sq_full_i).
  - While stalled, all outputs hold.
  - An LSQ transfer completes when wr && !full. The wr output then drops unless a new LSQ op is accepted in the same cycle.
- Regfile write: wb_regd_wr_o is a single-cycle pulse with no back-pressure. It is suppressed when regd_addr is 0.
- Write data priority: CSR data, then pc+inc when link, else ALU result.
- Branch resolution: taken = ids_jump_i || (ids_branch_i && cmp(funct3)). cmp covers BEQ/BNE/BLT/BGE/BLTU/BGEU; other funct3 values give not-taken.
  - Target = ALU result with bit 0 cleared. The decoder supplies pc+imm, or rs1+imm for JALR.
  - When taken, the next cycle raises hvec_vec_strobe_o for one cycle, with hvec_vec_o = target and hvec_pc_o = ids_pc_i.
- Squash: any instruction accepted while hvec_vec_strobe_o=1 (or hvec_misalign_o=1) is acked but has no effect: no wb, no lsq, no redirect.
- pc+inc: +4, or +2 when MERLIN_RVC_EN and ids_ilen_i=0. Arithmetic is modulo 2^C_XLEN; wrap is silent.
- Reset mid-stall: LSQ valids clear immediately and the pending op is lost.
- clk_en_i=0 during a stall: outputs hold and no transfer is credited.

Optional Feature:
MERLIN_RVC_EN.
- Defined: ids_ilen_i port exists and pc+inc follows ilen; target bit 1 is legal.
- Undefined: ids_ilen_i is absent and inc is always 4. A taken target with bit 1 set raises hvec_misalign_o, with hvec_pc_o = pc and no vec strobe.

Decomposition:
- merlin_pkg holds: t_zone enum, ALU opcode constants, funct3 branch constants, and the C_XLEN legality check.
- Sub-module alu_cmp: a combinational ALU plus branch comparator, parametrised on C_XLEN. It is instantiated once.

Test Plan:
- REGFILE ADD, left=5, right=7, rd=3 -> cycle N+1: wb_regd_wr_o=1, addr=3, data=12; lsq outputs stay 0.
- Load with lsq_lq_full_i=1 for 3 cycles, addr=0x100 -> lsq_lq_wr_o=1 and ids_ack_o=0 for 3 cycles; transfer completes on the 4th cycle; lsq_addr_o holds 0x100 throughout.
- BEQ regs1=regs2=9, target 0x2000, pc=0x1000 -> hvec_vec_strobe_o=1 for one cycle with vec=0x2000, hvec_pc_o=0x1000. The next accepted ADD rd=4 is squashed (no wb).
- JAL link, rd=1, pc=0xFFFFFFFC (C_XLEN=32) -> wb data=0x00000000 (wrap); redirect issued.
- With MERLIN_RVC_EN undefined, JALR target 0x1002 -> hvec_misalign_o pulse, no vec strobe. With it defined and ilen=0, link data = pc+2 and the redirect is issued.
- Assert resetb_i mid-stall -> all outputs read 0 before the next clock edge; with dav=1 after release, ack=1.
